lives_controller: RTL and testbench
===================================

Name: lives_controller

Overview:
Sequences the player-lives resource for the HUD lives display and the game core. It owns the lives count, runs the ready/death/game-over phases off a per-frame tick, and grants a one-time extra life at a score threshold. Its `lives` output drives the HUD lives renderer directly. Its `freeze` and `respawn` outputs gate the movement and ghost logic.

Parameters:
- START_LIVES, 3: lives loaded on game start (1..MAX_LIVES).
- MAX_LIVES, 5: saturation ceiling; equals the HUD icon capacity.
- READY_FRAMES, 120: frames held frozen before play resumes (>=1).
- DEATH_FRAMES, 90: frames of death animation before the decrement (>=1).
- EXTRA_LIFE_SCORE, 10000: score at which the single bonus life is granted.
- SCORE_W, 16: score bus width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start_game  in  1  pulse; start a new game.
- pacman_caught  in  1  pulse; a ghost caught Pac-Man.
- score  in  SCORE_W  current score, unsigned.
- lives  out  3  lives remaining, including the one in play; feeds the HUD.
- freeze  out  1  high means the game core holds all motion.
- respawn  out  1  one-cycle pulse; reset actor positions.
- game_over  out  1  high in the GAME_OVER state.
- extra_life  out  1  one-cycle pulse when the bonus life is granted.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, lives=0, freeze=1, respawn=0, game_over=0, extra_life=0, frame counter=0, bonus_given=0.
- States: IDLE, READY, PLAY, DYING, GAME_OVER.
- IDLE or GAME_OVER with start_game:
  - Next state READY.
  - lives<=START_LIVES, bonus_given<=0, counter<=READY_FRAMES.
  - respawn pulses in the cycle after start_game.
  - game_over clears.
- start_game in READY, PLAY or DYING: ignored.
- READY: freeze=1. Each frame_tick decrements the counter. A tick with counter==1 moves to PLAY (freeze=0 from the next cycle).
- PLAY: freeze=0.
  - pacman_caught moves to DYING with counter<=DEATH_FRAMES; freeze=1 from the next cycle.
  - pacman_caught outside PLAY is ignored.
- DYING: each frame_tick decrements the counter. A tick with counter==1 does the following:
  - lives<=lives-1.
  - If the result is 0: go to GAME_OVER; game_over=1, freeze=1.
  - Otherwise: go to READY, counter<=READY_FRAMES, respawn pulses.
- Extra life:
  - Trigger: score>=EXTRA_LIFE_SCORE, bonus_given==0, and state is READY, PLAY or DYING.
  - Action: bonus_given<=1; lives<=min(lives+1, MAX_LIVES); extra_life pulses one cycle.
  - The flag is set even when lives is saturated, so the bonus is lost, not deferred.
- Simultaneous extra-life grant and DYING decrement in the same cycle: net lives change is 0 (+1-1, saturation applied to the +1 first). The game-over test uses the net value.
- Simultaneous pacman_caught and extra-life grant in PLAY: both take effect.
- Arithmetic: lives is 3-bit unsigned and never wraps. The decrement only occurs from lives>=1.
- frame_tick while in IDLE, PLAY or GAME_OVER: no effect on the counter.
- rst asserted mid-sequence (any state): next cycle matches the reset values exactly; no pending pulse survives.

Optional Feature:
- Macro: LIVES_BLINK_EN.
- Defined: in DYING, `lives` toggles between lives and lives-1 every 8 frame_ticks (phase starts at the true value), so the HUD icon about to be lost blinks. The internal count is unaffected; on exit `lives` shows the true count.
- Undefined: `lives` always equals the internal count.

Decomposition:
- Shared package game_pkg holds:
  - the state enum typedef (IDLE, READY, PLAY, DYING, GAME_OVER);
  - the MAX_LIVES value shared with the HUD lives renderer;
  - the EXTRA_LIFE_SCORE value.
- Natural sub-module: frame_timer. It is a loadable down-counter advanced by frame_tick, with a `done` pulse on the terminal tick. It is reused for the READY and DYING timing.

Test Plan:
- Reset, then start_game: respawn high in cycle 2; lives=3; freeze=1 until 120 ticks elapse, then freeze=0 and state PLAY.
- pacman_caught in PLAY with lives=3: freeze=1 next cycle; after 90 ticks lives=2, respawn pulse, 120 ticks later PLAY.
- Three deaths from lives=3: final death leaves lives=0, game_over=1, freeze=1; then start_game restores lives=3 and clears game_over.
- Score goes 9999 -> 10000 in PLAY at lives=2: lives=3 and extra_life pulses once. Score 20000 later produces no second grant.
- lives=5 and score crosses 10000: lives stays 5, extra_life pulses, bonus flag set. A later death gives 4.
- Assert rst mid-DYING with counter=40: next cycle lives=0, freeze=1, state IDLE. Ticks then have no effect until start_game.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-wide types and constants used by the lives controller and the HUD.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READY     = 3'd1,
    PLAY      = 3'd2,
    DYING     = 3'd3,
    GAME_OVER = 3'd4
  } lives_state_e;

  // The HUD lives renderer draws exactly this many icons.
  localparam int GAME_MAX_LIVES        = 5;
  localparam int GAME_EXTRA_LIFE_SCORE = 10000;

  function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] ceil);
    return (v >= ceil) ? v : v + 3'd1;
  endfunction

  function automatic logic [2:0] floor_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

endpackage

// File: rtl/lives_controller_frame_timer.sv
// Loadable frame down-counter; done strobes on the tick that consumes the last frame.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         run,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  logic [W-1:0] count_r;

  // A load wins over a coincident tick so each phase starts at its full length.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (run && tick && (count_r != ZERO)) begin
      count_r <= count_r - ONE;
    end
  end

  assign done = run && tick && (count_r == ONE);

endmodule

// File: rtl/lives_controller.sv
// Player-lives sequencer: ready/death/game-over phasing and one-time bonus life.
// Build option LIVES_BLINK_EN: blink the about-to-be-lost HUD icon while dying.
module lives_controller
  import game_pkg::*;
#(
  parameter int START_LIVES      = 3,
  parameter int MAX_LIVES        = GAME_MAX_LIVES,
  parameter int READY_FRAMES     = 120,
  parameter int DEATH_FRAMES     = 90,
  parameter int EXTRA_LIFE_SCORE = GAME_EXTRA_LIFE_SCORE,
  parameter int SCORE_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_game,
  input  logic               pacman_caught,
  input  logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               freeze,
  output logic               respawn,
  output logic               game_over,
  output logic               extra_life
);

  localparam int CNT_MAX = (READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0]         START_L     = 3'(START_LIVES);
  localparam logic [2:0]         MAX_L       = 3'(MAX_LIVES);
  localparam logic [CNT_W-1:0]   READY_CNT   = CNT_W'(READY_FRAMES);
  localparam logic [CNT_W-1:0]   DEATH_CNT   = CNT_W'(DEATH_FRAMES);
  localparam logic [SCORE_W-1:0] BONUS_SCORE = SCORE_W'(EXTRA_LIFE_SCORE);

  lives_state_e     state_r;
  logic [2:0]       lives_r;
  logic             freeze_r;
  logic             respawn_r;
  logic             game_over_r;
  logic             extra_life_r;
  logic             bonus_given_r;

  logic             start_ok_s;
  logic             timer_run_s;
  logic             timer_done_s;
  logic             timer_load_s;
  logic [CNT_W-1:0] timer_val_s;
  logic             grant_s;
  logic [2:0]       lives_bonus_s;
  logic [2:0]       lives_net_s;
  logic [2:0]       lives_next_s;

  frame_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (frame_tick),
    .run      (timer_run_s),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .done     (timer_done_s)
  );

  // Next lives value and timer reload; the bonus +1 saturates before any death -1.
  always_comb begin
    start_ok_s    = start_game && ((state_r == IDLE) || (state_r == GAME_OVER));
    timer_run_s   = (state_r == READY) || (state_r == DYING);
    grant_s       = (timer_run_s || (state_r == PLAY)) && !bonus_given_r && (score >= BONUS_SCORE);
    lives_bonus_s = grant_s ? sat_inc(lives_r, MAX_L) : lives_r;
    lives_net_s   = floor_dec(lives_bonus_s);
    lives_next_s  = lives_r;
    timer_load_s  = 1'b0;
    timer_val_s   = READY_CNT;
    case (state_r)
      IDLE, GAME_OVER: begin
        if (start_ok_s) begin
          lives_next_s = START_L;
          timer_load_s = 1'b1;
        end else begin
          lives_next_s = lives_r;
        end
      end
      READY: begin
        lives_next_s = lives_bonus_s;
      end
      PLAY: begin
        lives_next_s = lives_bonus_s;
        if (pacman_caught) begin
          timer_load_s = 1'b1;
          timer_val_s  = DEATH_CNT;
        end else begin
          timer_load_s = 1'b0;
        end
      end
      DYING: begin
        if (timer_done_s) begin
          lives_next_s = lives_net_s;
          timer_load_s = (lives_net_s != 3'd0);
        end else begin
          lives_next_s = lives_bonus_s;
        end
      end
      default: begin
        lives_next_s = lives_r;
      end
    endcase
  end

  // Phase FSM with registered HUD/core outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      lives_r       <= 3'd0;
      freeze_r      <= 1'b1;
      respawn_r     <= 1'b0;
      game_over_r   <= 1'b0;
      extra_life_r  <= 1'b0;
      bonus_given_r <= 1'b0;
    end else begin
      lives_r      <= lives_next_s;
      respawn_r    <= 1'b0;
      extra_life_r <= grant_s;
      if (grant_s) begin
        bonus_given_r <= 1'b1;
      end
      case (state_r)
        IDLE, GAME_OVER: begin
          if (start_ok_s) begin
            state_r       <= READY;
            freeze_r      <= 1'b1;
            respawn_r     <= 1'b1;
            game_over_r   <= 1'b0;
            bonus_given_r <= 1'b0;
          end
        end
        READY: begin
          if (timer_done_s) begin
            state_r  <= PLAY;
            freeze_r <= 1'b0;
          end
        end
        PLAY: begin
          if (pacman_caught) begin
            state_r  <= DYING;
            freeze_r <= 1'b1;
          end
        end
        DYING: begin
          if (timer_done_s) begin
            freeze_r <= 1'b1;
            if (lives_net_s == 3'd0) begin
              state_r     <= GAME_OVER;
              game_over_r <= 1'b1;
            end else begin
              state_r   <= READY;
              respawn_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          freeze_r    <= 1'b1;
          game_over_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef LIVES_BLINK_EN
  logic [2:0] blink_cnt_r;
  logic       blink_phase_r;
  logic [2:0] lives_disp_r;
  logic       stay_dying_s;
  logic       phase_next_s;

  // Blink phase advances every 8th tick only while the death animation continues.
  always_comb begin
    stay_dying_s = (state_r == DYING) && !timer_done_s;
    if (frame_tick && (blink_cnt_r == 3'd7)) begin
      phase_next_s = ~blink_phase_r;
    end else begin
      phase_next_s = blink_phase_r;
    end
  end

  // Blink counter plus registered HUD value (true count whenever not blinking low).
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_r   <= 3'd0;
      blink_phase_r <= 1'b0;
      lives_disp_r  <= 3'd0;
    end else begin
      if (!stay_dying_s) begin
        blink_cnt_r   <= 3'd0;
        blink_phase_r <= 1'b0;
      end else if (frame_tick) begin
        blink_cnt_r   <= blink_cnt_r + 3'd1;
        blink_phase_r <= phase_next_s;
      end
      lives_disp_r <= (stay_dying_s && phase_next_s) ? floor_dec(lives_next_s) : lives_next_s;
    end
  end

  assign lives = lives_disp_r;
`else
  assign lives = lives_r;
`endif

  assign freeze     = freeze_r;
  assign respawn    = respawn_r;
  assign game_over  = game_over_r;
  assign extra_life = extra_life_r;

endmodule

// File: tb/tb_lives_controller.sv
// Directed bench for lives_controller: vector table plus multi-cycle phase sequences.
module tb_lives_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        frame_tick = 1'b0, start_game = 1'b0, pacman_caught = 1'b0;
  logic [15:0] score = 16'd0;
  logic [2:0]  lives;
  logic        freeze, respawn, game_over, extra_life;

  logic        tick5 = 1'b0, start5 = 1'b0, caught5 = 1'b0;
  logic [15:0] score5 = 16'd0;
  logic [2:0]  lives5;
  logic        freeze5, respawn5, game_over5, extra_life5;

  logic [6:0] obs, obs5;
  assign obs  = {lives, freeze, respawn, game_over, extra_life};
  assign obs5 = {lives5, freeze5, respawn5, game_over5, extra_life5};

  int checks = 0;
  int errors = 0;

  lives_controller dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .start_game    (start_game),
    .pacman_caught (pacman_caught),
    .score         (score),
    .lives         (lives),
    .freeze        (freeze),
    .respawn       (respawn),
    .game_over     (game_over),
    .extra_life    (extra_life)
  );

  lives_controller #(.START_LIVES(5)) dut5 (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (tick5),
    .start_game    (start5),
    .pacman_caught (caught5),
    .score         (score5),
    .lives         (lives5),
    .freeze        (freeze5),
    .respawn       (respawn5),
    .game_over     (game_over5),
    .extra_life    (extra_life5)
  );

  typedef struct {
    logic        rst;
    logic        start;
    logic        caught;
    logic        tick;
    logic [15:0] score;
    logic [6:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [6:0] pk(input int l, input logic f, input logic r,
                                    input logic g, input logic x);
    logic [2:0] l3;
    l3 = 3'(l);
    return {l3, f, r, g, x};
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got lives=%0d freeze=%b respawn=%b game_over=%b extra_life=%b, want lives=%0d freeze=%b respawn=%b game_over=%b extra_life=%b",
               name, act[6:4], act[3], act[2], act[1], act[0],
               exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic cyc(input logic sel, input logic s, input logic c, input logic t);
    if (sel) begin
      start5 = s; caught5 = c; tick5 = t;
    end else begin
      start_game = s; pacman_caught = c; frame_tick = t;
    end
    @(posedge clk);
    #1;
    start_game = 1'b0; pacman_caught = 1'b0; frame_tick = 1'b0;
    start5 = 1'b0; caught5 = 1'b0; tick5 = 1'b0;
  endtask

  task automatic ticks(input logic sel, input int n);
    for (int i = 0; i < n; i++) cyc(sel, 1'b0, 1'b0, 1'b1);
  endtask

  // Catch in PLAY, then run the full death animation on the main DUT.
  task automatic die();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1'b0, 89);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic to_play(input string name, input int l);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(1'b0, 120);
    chk(name, obs, pk(l, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, pk(0, 1, 0, 0, 0), "reset"};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0, pk(0, 1, 0, 0, 0), "idle_tick"};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, pk(0, 1, 0, 0, 0), "idle_caught"};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, pk(3, 1, 1, 0, 0), "start"};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, pk(3, 1, 0, 0, 0), "ready_hold"};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, pk(3, 1, 0, 0, 0), "ready_start_ignored"};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, pk(3, 1, 0, 0, 0), "ready_caught_ignored"};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0, pk(3, 1, 0, 0, 0), "ready_tick1"};

    for (int i = 0; i < 8; i++) begin
      rst = vecs[i].rst;
      start_game = vecs[i].start;
      pacman_caught = vecs[i].caught;
      frame_tick = vecs[i].tick;
      score = vecs[i].score;
      @(posedge clk);
      #1;
      chk(vecs[i].name, obs, vecs[i].exp);
      rst = 1'b0; start_game = 1'b0; pacman_caught = 1'b0; frame_tick = 1'b0;
    end

    // READY lasts exactly 120 ticks.
    ticks(1'b0, 118);
    chk("ready_tick119", obs, pk(3, 1, 0, 0, 0));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("play_entry", obs, pk(3, 0, 0, 0, 0));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("play_tick_ignored", obs, pk(3, 0, 0, 0, 0));

    // First death from 3 lives.
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("caught_freeze", obs, pk(3, 1, 0, 0, 0));
    ticks(1'b0, 89);
    chk("dying_tick89", obs, pk(3, 1, 0, 0, 0));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("death_to_2", obs, pk(2, 1, 1, 0, 0));
    to_play("replay_2", 2);

    // Bonus life at the threshold, granted once.
    score = 16'd9999;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("score_9999", obs, pk(2, 0, 0, 0, 0));
    score = 16'd10000;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bonus_grant", obs, pk(3, 0, 0, 0, 1));
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bonus_one_pulse", obs, pk(3, 0, 0, 0, 0));
    score = 16'd20000;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("no_second_bonus", obs, pk(3, 0, 0, 0, 0));

    // Three deaths to game over.
    die();
    chk("death_a", obs, pk(2, 1, 1, 0, 0));
    to_play("back_play_a", 2);
    die();
    chk("death_b", obs, pk(1, 1, 1, 0, 0));
    to_play("back_play_b", 1);
    die();
    chk("game_over", obs, pk(0, 1, 0, 1, 0));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("go_tick", obs, pk(0, 1, 0, 1, 0));
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("go_caught", obs, pk(0, 1, 0, 1, 0));
    score = 16'd0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("restart", obs, pk(3, 1, 1, 0, 0));
    to_play("play_again", 3);

    // Bonus and final death tick in the same cycle cancel out.
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1'b0, 89);
    score = 16'd10000;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("grant_and_death", obs, pk(3, 1, 1, 0, 1));
    to_play("after_grant_death", 3);

    // Reset mid-death with 40 frames left.
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1'b0, 50);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_dying", obs, pk(0, 1, 0, 0, 0));
    ticks(1'b0, 5);
    chk("post_rst_ticks", obs, pk(0, 1, 0, 0, 0));
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_caught", obs, pk(0, 1, 0, 0, 0));
    score = 16'd0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("start_after_rst", obs, pk(3, 1, 1, 0, 0));

    // Saturated bonus on the START_LIVES=5 instance, coincident with a catch.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat_start", obs5, pk(5, 1, 1, 0, 0));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1'b1, 120);
    chk("sat_play", obs5, pk(5, 0, 0, 0, 0));
    score5 = 16'd9999;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat_9999", obs5, pk(5, 0, 0, 0, 0));
    score5 = 16'd10000;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("sat_bonus_caught", obs5, pk(5, 1, 0, 0, 1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat_pulse_once", obs5, pk(5, 1, 0, 0, 0));
    ticks(1'b1, 89);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("sat_death", obs5, pk(4, 1, 1, 0, 0));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat_flag_kept", obs5, pk(4, 1, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
